srlor_bank_sched: RTL and testbench
===================================

Name: srlor_bank_sched

Overview:
- Clocked scheduler that shares a bank of NLAT enable-gated SR latch cells between NREQ requesters.
- Each requester issues a four-phase write request (latch index plus value). The block round-robin arbitrates, drives the selected cell's S and active-low E, waits for settle, and checks the latch output through a synchroniser.
- It retries on mismatch, then acknowledges with a pass/fail flag.
- It also sequences a bank-wide clear through the cells' reset input.
- Sits between synchronous control logic and the latch bank in self-timed/clocked boundary designs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NLAT, 8, number of latch cells (2..32); IW = $clog2(NLAT).
- SETTLE, 2, cycles E held low per write attempt (1..15).
- MAX_RETRY, 3, extra write attempts after a failed check (0..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request, four-phase.
- req_idx  in  NREQ*IW  target cell index; slice i belongs to requester i.
- req_val  in  NREQ  value to store (1=set, 0=clear).
- ack  out  NREQ  per-requester acknowledge.
- err  out  NREQ  valid while ack[i]=1; 1 = readback mismatch after all retries.
- clr  in  1  bank clear request, level; serviced only from IDLE.
- busy  out  1  high in any state other than IDLE.
- lat_s  out  NLAT  S input of each cell.
- lat_e  out  NLAT  E input of each cell; low = transparent, high = hold.
- lat_rst  out  1  shared reset to all cells.
- lat_q  in  NLAT  cell outputs; asynchronous, synchronised internally.

Behaviour:
- Reset (async, rst=1): state=IDLE; ack=0; err=0; lat_e all 1; lat_s all 0; lat_rst=1 while rst high; round-robin pointer=0; retry count=0; synchroniser flops=0.
- lat_q passes through a 2-flop synchroniser before any comparison.
- All outputs are registered.
- States:
  - IDLE:
    - clr=1 -> CLEAR, with priority over req.
    - Else any req -> grant the first requester at or after the pointer, in ascending modulo order. Latch g, idx and val; retry count=0 -> SETUP.
  - CLEAR: lat_rst=1 for SETTLE cycles, lat_e held 1 -> IDLE. clr is not acknowledged; it is level-serviced. A still-high clr re-enters CLEAR, but at most once per IDLE visit, so pending req starvation is prevented by servicing one req between consecutive clears.
  - SETUP (1 cycle): lat_s[idx]=val; all lat_e still 1 -> WRITE.
  - WRITE (SETTLE cycles): lat_e[idx]=0; others 1; lat_s[idx] stable -> SYNC.
  - SYNC (3 cycles): lat_e[idx]=1, lat_s[idx] held. Compare synchronised lat_q[idx] with val on the last cycle.
    - Match -> ACK with err[g]=0.
    - Mismatch and retry count < MAX_RETRY -> increment, SETUP.
    - Else -> ACK with err[g]=1.
  - ACK: ack[g]=1 and err[g] valid. Stay until req[g]=0, then ack[g]=0, err[g]=0, pointer=(g+1) mod NREQ -> IDLE.
- Only one lat_e bit is ever low at a time. lat_s returns to 0 on entering IDLE.
- Requesters must hold idx/val stable while req=1; the block uses the values captured at grant.
- Changing req_idx/val or dropping req before ack: the in-flight operation completes regardless. An early-dropped req simply sees ack rise then fall one cycle later (the ACK exit condition is already true).
- idx >= NLAT: no write performed; go straight to ACK with err=1.
- Reset mid-operation: immediate return to reset values; the cell's content is undefined, then cleared by lat_rst during rst.
- Simultaneous clr and req in IDLE: CLEAR first; the req is granted in the next IDLE.

Test Plan:
- Reset and single write: rst pulse, then req[0]=1, idx=3, val=1. Expect lat_s[3]=1, lat_e[3]=0 for exactly 2 cycles, ack[0]=1 with err=0 six cycles after grant. Model latch shows q[3]=1.
- Round robin: req[0..3] all high continuously. Expect grant order 0,1,2,3,0; each ack drops one cycle after its req falls.
- Retry/fail: latch model stuck at 0, write val=1 to idx 5, MAX_RETRY=3. Expect 4 WRITE pulses on lat_e[5], then ack[0]=1, err[0]=1.
- Clear priority: clr=1 and req[1]=1 in the same IDLE cycle. Expect lat_rst high 2 cycles, then req[1] serviced; all model q=0 before that write.
- Out-of-range index (NLAT=6): idx=7. Expect no lat_e activity, ack=1, err=1.
- Async reset mid-WRITE: assert rst while lat_e[2]=0. Expect lat_e all 1 and ack=0 in the same cycle without a clock edge, lat_rst=1 while rst high.

Source files
------------

// File: rtl/srlor_bank_sched.sv
// Round-robin scheduler that shares a bank of enable-gated SR latch cells between requesters:
// it writes a cell, reads it back through a synchroniser, retries on mismatch and sequences bank clears.
module srlor_bank_sched #(
    parameter  int NREQ      = 4,
    parameter  int NLAT      = 8,
    parameter  int SETTLE    = 2,
    parameter  int MAX_RETRY = 3,
    localparam int IW        = $clog2(NLAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IW-1:0]   req_idx,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    input  logic                 clr,
    output logic                 busy,
    output logic [NLAT-1:0]      lat_s,
    output logic [NLAT-1:0]      lat_e,
    output logic                 lat_rst,
    input  logic [NLAT-1:0]      lat_q
);

    localparam int             PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]    NLAT_L = (IW+1)'(NLAT);
    localparam logic [3:0]     SET_LAST  = 4'(SETTLE - 1);
    localparam logic [3:0]     SYNC_LAST = 4'd2;
    localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETUP,
        S_WRITE,
        S_SYNC,
        S_ACK
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt;
    logic [IW-1:0]     idx_r;
    logic              val_r;
    logic [2:0]        retry;
    logic [3:0]        cnt;
    logic              clr_block;
    logic [NLAT-1:0]   sync1;
    logic [NLAT-1:0]   sync2;

    logic              any_req;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     cand;
    logic [IW-1:0]     sel_idx;
    logic              sel_idx_ok;

    // NOTE: every signal driven in always_comb gets a default up front so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    assign sel_idx    = req_idx[int'(sel)*IW +: IW];
    assign sel_idx_ok = ({1'b0, sel_idx} < NLAT_L);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            idx_r     <= '0;
            val_r     <= 1'b0;
            retry     <= '0;
            cnt       <= '0;
            clr_block <= 1'b0;
            sync1     <= '0;
            sync2     <= '0;
            ack       <= '0;
            err       <= '0;
            busy      <= 1'b0;
            lat_s     <= '0;
            lat_e     <= '1;
            lat_rst   <= 1'b1;
        end else begin
            sync1 <= lat_q;
            sync2 <= sync1;
            case (state)
                S_IDLE: begin
                    lat_rst <= 1'b0;
                    lat_s   <= '0;
                    lat_e   <= '1;
                    // One clear per IDLE visit keeps a held clr from starving pending requests.
                    if (clr && !clr_block) begin
                        state   <= S_CLEAR;
                        lat_rst <= 1'b1;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end else if (any_req) begin
                        gnt       <= sel;
                        idx_r     <= sel_idx;
                        val_r     <= req_val[sel];
                        retry     <= '0;
                        clr_block <= 1'b0;
                        busy      <= 1'b1;
                        if (sel_idx_ok) begin
                            state          <= S_SETUP;
                            lat_s[sel_idx] <= req_val[sel];
                        end else begin
                            state    <= S_ACK;
                            ack[sel] <= 1'b1;
                            err[sel] <= 1'b1;
                        end
                    end else begin
                        clr_block <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (cnt == SET_LAST) begin
                        state     <= S_IDLE;
                        lat_rst   <= 1'b0;
                        clr_block <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_SETUP: begin
                    state        <= S_WRITE;
                    lat_e[idx_r] <= 1'b0;
                    cnt          <= '0;
                end
                S_WRITE: begin
                    if (cnt == SET_LAST) begin
                        state <= S_SYNC;
                        lat_e <= '1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        if (sync2[idx_r] == val_r) begin
                            state    <= S_ACK;
                            ack[gnt] <= 1'b1;
                            err[gnt] <= 1'b0;
                        end else if (retry < RETRY_MAX) begin
                            state <= S_SETUP;
                            retry <= retry + 3'd1;
                        end else begin
                            state    <= S_ACK;
                            ack[gnt] <= 1'b1;
                            err[gnt] <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_ACK: begin
                    if (!req[gnt]) begin
                        state    <= S_IDLE;
                        ack[gnt] <= 1'b0;
                        err[gnt] <= 1'b0;
                        lat_s    <= '0;
                        busy     <= 1'b0;
                        ptr      <= (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srlor_bank_sched.sv
// Scoreboard bench for srlor_bank_sched: a behavioural latch bank closes the write/readback loop,
// and a second instance with a 6-cell bank covers out-of-range indices.
module tb_srlor_bank_sched;

    localparam int NREQ = 4;
    localparam int NLAT = 8;
    localparam int IW   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req, req_val, ack, err;
    logic [NREQ*IW-1:0]  req_idx;
    logic                clr, busy, lat_rst;
    logic [NLAT-1:0]     lat_s, lat_e, lat_q;
    logic [NLAT-1:0]     q_model, stuck0;

    logic [1:0]          req6, val6, ack6, err6;
    logic [5:0]          idx6;
    logic                busy6, lat_rst6;
    logic [5:0]          lat_s6, lat_e6;
    logic [5:0]          lat_q6;
    logic                clr6;

    assign lat_q  = q_model;
    assign lat_q6 = '0;
    assign clr6   = 1'b0;

    // Enable-gated SR cell model; stuck0 forces a cell to ignore writes of 1.
    always_latch begin
        for (int i = 0; i < NLAT; i++) begin
            if (lat_rst)        q_model[i] <= 1'b0;
            else if (!lat_e[i]) q_model[i] <= lat_s[i] & ~stuck0[i];
        end
    end

    srlor_bank_sched #(.NREQ(NREQ), .NLAT(NLAT), .SETTLE(2), .MAX_RETRY(3)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_idx(req_idx), .req_val(req_val),
        .ack(ack), .err(err), .clr(clr), .busy(busy),
        .lat_s(lat_s), .lat_e(lat_e), .lat_rst(lat_rst), .lat_q(lat_q)
    );

    srlor_bank_sched #(.NREQ(2), .NLAT(6), .SETTLE(2), .MAX_RETRY(3)) u_dut6 (
        .clk(clk), .rst(rst), .req(req6), .req_idx(idx6), .req_val(val6),
        .ack(ack6), .err(err6), .clr(clr6), .busy(busy6),
        .lat_s(lat_s6), .lat_e(lat_e6), .lat_rst(lat_rst6), .lat_q(lat_q6)
    );

    typedef struct {
        int   g;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic apply_reset();
        rst    = 1'b1;
        req    = '0;
        req6   = '0;
        clr    = 1'b0;
        stuck0 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives one four-phase write on the main instance and reports what the latch interface did.
    task automatic run_write(input int g, input int idx, input logic val, input logic with_clr,
                             output int ack_at, output int low_cycles, output int pulses,
                             output int rst_cycles, output logic [NLAT-1:0] q_at_setup,
                             output logic proto_ok);
        logic prev_low, cur_low, seen_setup;
        exp_t e;
        req_idx[g*IW +: IW] = IW'(idx);
        req_val[g] = val;
        req[g]     = 1'b1;
        if (with_clr) clr = 1'b1;
        ack_at = -1; low_cycles = 0; pulses = 0; rst_cycles = 0;
        q_at_setup = '1; proto_ok = 1'b1; prev_low = 1'b0; seen_setup = 1'b0;
        for (int n = 1; n <= 60 && ack_at < 0; n++) begin
            @(negedge clk);
            if (lat_rst) rst_cycles++;
            if (!seen_setup && lat_s != '0) begin
                seen_setup = 1'b1;
                q_at_setup = q_model;
                clr        = 1'b0;
            end
            if ($countones(~lat_e) > 1) proto_ok = 1'b0;
            cur_low = !lat_e[idx];
            if (cur_low && lat_s[idx] !== val) proto_ok = 1'b0;
            if (cur_low) low_cycles++;
            if (cur_low && !prev_low) pulses++;
            prev_low = cur_low;
            if (ack[g]) ack_at = n;
        end
        checks++;
        if (ack_at < 0) begin
            failures++;
            $display("FAIL ack_timeout req=%0d got=none exp=ack within 60 cycles", g);
        end else if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty req=%0d got=ack exp=no pending entry", g);
        end else begin
            e = sb.pop_front();
            checks++;
            if (ack !== (NREQ'(1) << e.g)) begin
                failures++;
                $display("FAIL ack_vector got=%b exp=%b", ack, NREQ'(1) << e.g);
            end
            checks++;
            if (err[g] !== e.err) begin
                failures++;
                $display("FAIL err_flag req=%0d got=%b exp=%b", g, err[g], e.err);
            end
        end
        req[g] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack[g] !== 1'b0 || err[g] !== 1'b0) begin
            failures++;
            $display("FAIL ack_release req=%0d got ack=%b err=%b exp=0/0", g, ack[g], err[g]);
        end
        checks++;
        if (busy !== 1'b0 || lat_s !== '0) begin
            failures++;
            $display("FAIL idle_return got busy=%b lat_s=%b exp=0/0", busy, lat_s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req6 = '0; req_val = '0; req_idx = '0;
        val6 = '0; idx6 = '0; clr = 1'b0; stuck0 = '0;
        @(negedge clk);
        checks++;
        if (ack !== '0 || err !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake got ack=%b err=%b busy=%b exp=0", ack, err, busy);
        end
        checks++;
        if (lat_e !== '1 || lat_s !== '0 || lat_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_latch_if got e=%b s=%b rst=%b exp=ff/00/1", lat_e, lat_s, lat_rst);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (lat_rst !== 1'b0 || q_model !== '0) begin
            failures++;
            $display("FAIL reset_release got lat_rst=%b q=%b exp=0/00", lat_rst, q_model);
        end
    endtask

    task automatic test_single_write();
        int at, low, pul, rc;
        logic [NLAT-1:0] qs;
        logic ok;
        apply_reset();
        sb.push_back('{g: 0, err: 1'b0});
        run_write(0, 3, 1'b1, 1'b0, at, low, pul, rc, qs, ok);
        checks++;
        if (at !== 7) begin
            failures++;
            $display("FAIL single_ack_latency got=%0d exp=7 negedges", at);
        end
        checks++;
        if (low !== 2 || pul !== 1 || !ok) begin
            failures++;
            $display("FAIL single_write_pulse got low=%0d pulses=%0d ok=%b exp=2/1/1", low, pul, ok);
        end
        checks++;
        if (q_model[3] !== 1'b1) begin
            failures++;
            $display("FAIL single_cell_value got=%b exp=1", q_model[3]);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   g;
        logic got;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_idx[i*IW +: IW] = IW'(i + 1);
            req_val[i] = 1'b1;
        end
        sb.push_back('{g: 0, err: 1'b0});
        sb.push_back('{g: 1, err: 1'b0});
        sb.push_back('{g: 2, err: 1'b0});
        sb.push_back('{g: 3, err: 1'b0});
        sb.push_back('{g: 0, err: 1'b0});
        req = '1;
        for (int k = 0; k < 5; k++) begin
            got = 1'b0;
            for (int n = 0; n < 40 && !got; n++) begin
                @(negedge clk);
                if (ack != '0) got = 1'b1;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL rr_timeout grant=%0d got=none exp=ack within 40 cycles", k);
                break;
            end
            e = sb.pop_front();
            checks++;
            if (ack !== (NREQ'(1) << e.g) || err !== '0) begin
                failures++;
                $display("FAIL rr_order grant=%0d got ack=%b err=%b exp ack=%b err=0",
                         k, ack, err, NREQ'(1) << e.g);
            end
            g = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) g = i;
            req[g] = 1'b0;
            @(negedge clk);
            checks++;
            if (ack[g] !== 1'b0) begin
                failures++;
                $display("FAIL rr_ack_drop req=%0d got=%b exp=0", g, ack[g]);
            end
            if (k < 4) req[g] = 1'b1;
            else       req    = '0;
        end
        req = '0;
        repeat (2) @(negedge clk);
        sb.delete();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_final_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_retry_fail();
        int at, low, pul, rc;
        logic [NLAT-1:0] qs;
        logic ok;
        apply_reset();
        stuck0 = 8'b0010_0000;
        sb.push_back('{g: 0, err: 1'b1});
        run_write(0, 5, 1'b1, 1'b0, at, low, pul, rc, qs, ok);
        checks++;
        if (pul !== 4 || low !== 8 || !ok) begin
            failures++;
            $display("FAIL retry_pulses got pulses=%0d low=%0d ok=%b exp=4/8/1", pul, low, ok);
        end
        checks++;
        if (at !== 25) begin
            failures++;
            $display("FAIL retry_ack_latency got=%0d exp=25 negedges", at);
        end
        checks++;
        if (q_model[5] !== 1'b0) begin
            failures++;
            $display("FAIL retry_cell_value got=%b exp=0", q_model[5]);
        end
        stuck0 = '0;
    endtask

    task automatic test_clear_priority();
        int at, low, pul, rc;
        logic [NLAT-1:0] qs;
        logic ok;
        apply_reset();
        sb.push_back('{g: 2, err: 1'b0});
        run_write(2, 4, 1'b1, 1'b0, at, low, pul, rc, qs, ok);
        checks++;
        if (q_model[4] !== 1'b1) begin
            failures++;
            $display("FAIL clear_precondition got=%b exp=1", q_model[4]);
        end
        // clr is held until the write starts: the first IDLE after the clear must grant req[1].
        sb.push_back('{g: 1, err: 1'b0});
        run_write(1, 6, 1'b1, 1'b1, at, low, pul, rc, qs, ok);
        checks++;
        if (rc !== 2) begin
            failures++;
            $display("FAIL clear_rst_cycles got=%0d exp=2", rc);
        end
        checks++;
        if (qs !== '0) begin
            failures++;
            $display("FAIL clear_bank_zero got=%b exp=00000000", qs);
        end
        checks++;
        if (at !== 10 || !ok) begin
            failures++;
            $display("FAIL clear_then_write got ack_at=%0d ok=%b exp=10/1", at, ok);
        end
        checks++;
        if (q_model !== 8'b0100_0000) begin
            failures++;
            $display("FAIL clear_final_bank got=%b exp=01000000", q_model);
        end
    endtask

    task automatic test_out_of_range();
        int   at;
        logic active;
        exp_t e;
        apply_reset();
        idx6[2:0] = 3'd7;
        val6[0]   = 1'b1;
        req6[0]   = 1'b1;
        sb.push_back('{g: 0, err: 1'b1});
        at = -1; active = 1'b0;
        for (int n = 1; n <= 20 && at < 0; n++) begin
            @(negedge clk);
            if (lat_e6 !== '1 || lat_s6 !== '0) active = 1'b1;
            if (ack6[0]) at = n;
        end
        checks++;
        if (at !== 1) begin
            failures++;
            $display("FAIL oor_ack_latency got=%0d exp=1", at);
        end
        e = sb.pop_front();
        checks++;
        if (err6[0] !== e.err || ack6 !== 2'b01) begin
            failures++;
            $display("FAIL oor_err got ack=%b err=%b exp ack=01 err=%b", ack6, err6, e.err);
        end
        req6[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (lat_e6 !== '1 || lat_s6 !== '0) active = 1'b1;
        end
        checks++;
        if (active || ack6 !== '0) begin
            failures++;
            $display("FAIL oor_no_write got active=%b ack=%b exp=0/00", active, ack6);
        end
    endtask

    task automatic test_async_reset();
        logic found;
        apply_reset();
        req_idx[0 +: IW] = 3'd2;
        req_val[0] = 1'b1;
        req[0]     = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (lat_e[2] === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL arst_reach_write got=no low enable exp=lat_e[2]=0");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (lat_e !== '1 || ack !== '0 || lat_rst !== 1'b1 || lat_s !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate got e=%b ack=%b rst=%b s=%b busy=%b exp=ff/0/1/00/0",
                     lat_e, ack, lat_rst, lat_s, busy);
        end
        @(negedge clk);
        checks++;
        if (lat_rst !== 1'b1 || q_model[2] !== 1'b0) begin
            failures++;
            $display("FAIL arst_held got lat_rst=%b q2=%b exp=1/0", lat_rst, q_model[2]);
        end
        req = '0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (lat_rst !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
            failures++;
            $display("FAIL arst_release got lat_rst=%b busy=%b ack=%b exp=0/0/0", lat_rst, busy, ack);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_retry_fail();
        test_clear_priority();
        test_out_of_range();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
